// File: rtl/one_hot_monitor_pkg.sv
// Shared types and helpers for the one-hot ring monitor.
//   state_t    : monitor FSM states (IDLE, TRACK, FAULT)
//   rot        : one-step rotation of a one-hot code inside a WIDTH-bit ring
//   is_one_hot : true when exactly one bit is set
//   encode     : binary position of the set bit
// Helpers work on MAX_W-bit zero-extended vectors so any WIDTH up to MAX_W fits.
package one_hot_monitor_pkg;

    localparam int unsigned MAX_W  = 32;
    localparam int unsigned MAX_IW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Rotate the low 'width' bits by one place; left moves bit i to bit i+1.
    function automatic logic [MAX_W-1:0] rot(input logic [MAX_W-1:0] code,
                                             input int unsigned       width,
                                             input logic              left);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                if (left) begin
                    r[MAX_IW'((i + 1) % width)] = code[MAX_IW'(i)];
                end else begin
                    r[MAX_IW'((i + width - 1) % width)] = code[MAX_IW'(i)];
                end
            end
        end
        return r;
    endfunction

    function automatic logic is_one_hot(input logic [MAX_W-1:0] code);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            cnt = cnt + 32'(code[MAX_IW'(i)]);
        end
        return (cnt == 1);
    endfunction

    // Highest set bit wins; the result is only meaningful for a legal code.
    function automatic logic [MAX_IW-1:0] encode(input logic [MAX_W-1:0] code);
        logic [MAX_IW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (code[MAX_IW'(i)]) begin
                idx = MAX_IW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/one_hot_monitor_onehot_encoder.sv
// Combinational one-hot to binary encoder with legality flag.
//   onehot_in : WIDTH-bit code under test
//   index_c   : binary position of the set bit (don't-care when illegal)
//   legal_c   : exactly one bit of onehot_in is set
module onehot_encoder
    import one_hot_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot_in,
    output logic [IW-1:0]    index_c,
    output logic             legal_c
);

    logic [MAX_W-1:0] wide;

    assign wide    = MAX_W'(onehot_in);
    assign index_c = IW'(encode(wide));
    assign legal_c = is_one_hot(wide);

endmodule

// File: rtl/one_hot_monitor.sv
// On-line integrity checker for a one-hot ring counter.
//   clock, reset : rising-edge clock, async active-high reset
//   enable       : counter advance enable (same signal the counter sees)
//   onehot_in    : counter output
//   clear_err    : synchronous clear of err_sticky / err_count
//   index, index_valid : encoded position of the active bit and its validity
//   wrap_pulse, rev_count : revolution pulse and modulo-256 revolution count
//   illegal, seq_err      : error pulses (bad code / out-of-sequence step)
//   err_sticky, err_count : latched error flag and saturating error count
//   state        : FSM state for debug
// Every output is registered and reports the code sampled at the previous edge.
module one_hot_monitor
    import one_hot_monitor_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          ROT_LEFT = 1'b1,
    parameter int unsigned IW       = $clog2(WIDTH)  // derived, leave at default
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] onehot_in,
    input  logic             clear_err,
    output logic [IW-1:0]    index,
    output logic             index_valid,
    output logic             wrap_pulse,
    output logic [7:0]       rev_count,
    output logic             illegal,
    output logic             seq_err,
    output logic             err_sticky,
    output logic [7:0]       err_count,
    output logic [1:0]       state
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic             en_q;
    logic [IW-1:0]    index_q, index_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       rev_q, rev_d;
    logic             illegal_q, illegal_d;
    logic             seq_q, seq_d;
    logic             sticky_q, sticky_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [IW-1:0]    enc_index_c;
    logic             enc_legal_c;
    logic [WIDTH-1:0] expected_c;
    logic             wrap_src_c;

    onehot_encoder #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_encoder (
        .onehot_in (onehot_in),
        .index_c   (enc_index_c),
        .legal_c   (enc_legal_c)
    );

    // Successor of the previously sampled code; unchanged when the counter held.
    assign expected_c = en_q ? WIDTH'(rot(MAX_W'(prev_q), WIDTH, ROT_LEFT)) : prev_q;
    assign wrap_src_c = ROT_LEFT ? prev_q[WIDTH-1] : prev_q[0];

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            en_q      <= 1'b0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            rev_q     <= '0;
            illegal_q <= 1'b0;
            seq_q     <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= onehot_in;
            en_q      <= enable;
            index_q   <= index_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            rev_q     <= rev_d;
            illegal_q <= illegal_d;
            seq_q     <= seq_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state, tracking and error bookkeeping.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        valid_d   = valid_q;
        wrap_d    = 1'b0;
        rev_d     = rev_q;
        illegal_d = 1'b0;
        seq_d     = 1'b0;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;

        case (state_q)
            // IDLE and FAULT accept any legal code without a sequence check.
            IDLE, FAULT: begin
                if (enc_legal_c) begin
                    state_d = TRACK;
                    index_d = enc_index_c;
                    valid_d = 1'b1;
                end else begin
                    state_d   = FAULT;
                    illegal_d = 1'b1;
                    valid_d   = 1'b0;
                end
            end
            TRACK: begin
                if (!enc_legal_c) begin
                    state_d   = FAULT;
                    illegal_d = 1'b1;
                    valid_d   = 1'b0;
                end else begin
                    index_d = enc_index_c;
                    valid_d = 1'b1;
                    if (onehot_in != expected_c) begin
                        // Resynchronise on the new value.
                        seq_d = 1'b1;
                    end else if (en_q && wrap_src_c) begin
                        wrap_d = 1'b1;
                        rev_d  = rev_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // A new error outranks a simultaneous clear.
        if (illegal_d || seq_d) begin
            sticky_d = 1'b1;
            if (clear_err) begin
                cnt_d = 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (clear_err) begin
            sticky_d = 1'b0;
            cnt_d    = 8'd0;
        end
    end

    assign index       = index_q;
    assign index_valid = valid_q;
    assign wrap_pulse  = wrap_q;
    assign rev_count   = rev_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_q;
    assign err_sticky  = sticky_q;
    assign err_count   = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_one_hot_monitor.sv
// Directed, table-driven bench for one_hot_monitor (WIDTH=8, ROT_LEFT=1).
module tb_one_hot_monitor;

    typedef struct packed {
        logic [2:0] idx;
        logic       valid;
        logic       wrap;
        logic [7:0] rev;
        logic       ill;
        logic       seq;
        logic       sticky;
        logic [7:0] cnt;
        logic [1:0] st;
    } obs_t;

    typedef struct {
        logic       en;
        logic [7:0] code;
        logic       clr;
        obs_t       exp;
    } vec_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] onehot_in;
    logic       clear_err;
    logic [2:0] index;
    logic       index_valid;
    logic       wrap_pulse;
    logic [7:0] rev_count;
    logic       illegal;
    logic       seq_err;
    logic       err_sticky;
    logic [7:0] err_count;
    logic [1:0] state;

    int n_vec;
    int n_miss;

    one_hot_monitor #(
        .WIDTH    (8),
        .ROT_LEFT (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .onehot_in   (onehot_in),
        .clear_err   (clear_err),
        .index       (index),
        .index_valid (index_valid),
        .wrap_pulse  (wrap_pulse),
        .rev_count   (rev_count),
        .illegal     (illegal),
        .seq_err     (seq_err),
        .err_sticky  (err_sticky),
        .err_count   (err_count),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic obs_t mk(input int idx, input bit valid, input bit wrap, input int rev,
                                input bit ill, input bit seq, input bit sticky, input int cnt,
                                input logic [1:0] st);
        obs_t o;
        o.idx    = 3'(idx);
        o.valid  = valid;
        o.wrap   = wrap;
        o.rev    = 8'(rev);
        o.ill    = ill;
        o.seq    = seq;
        o.sticky = sticky;
        o.cnt    = 8'(cnt);
        o.st     = st;
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t o;
        o.idx    = index;
        o.valid  = index_valid;
        o.wrap   = wrap_pulse;
        o.rev    = rev_count;
        o.ill    = illegal;
        o.seq    = seq_err;
        o.sticky = err_sticky;
        o.cnt    = err_count;
        o.st     = state;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = actual();
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got idx=%0d v=%0b wrap=%0b rev=%0d ill=%0b seq=%0b stk=%0b cnt=%0d st=%0d | want idx=%0d v=%0b wrap=%0b rev=%0d ill=%0b seq=%0b stk=%0b cnt=%0d st=%0d",
                     name, got.idx, got.valid, got.wrap, got.rev, got.ill, got.seq, got.sticky, got.cnt, got.st,
                     exp.idx, exp.valid, exp.wrap, exp.rev, exp.ill, exp.seq, exp.sticky, exp.cnt, exp.st);
        end
    endtask

    // Drive inputs, take one rising edge, settle just after it.
    task automatic step(input logic en, input logic [7:0] code, input logic clr);
        enable    = en;
        onehot_in = code;
        clear_err = clr;
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[$];

    task automatic add(input logic en, input logic [7:0] code, input logic clr, input obs_t exp);
        vec_t v;
        v.en   = en;
        v.code = code;
        v.clr  = clr;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // Full revolution from reset
        add(1, 8'h01, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h02, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h04, 0, mk(2, 1, 0, 0, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h08, 0, mk(3, 1, 0, 0, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h10, 0, mk(4, 1, 0, 0, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h20, 0, mk(5, 1, 0, 0, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h40, 0, mk(6, 1, 0, 0, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h80, 0, mk(7, 1, 0, 0, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h01, 0, mk(0, 1, 1, 1, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h02, 0, mk(1, 1, 0, 1, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h04, 0, mk(2, 1, 0, 1, 0, 0, 0, 0, S_TRACK));
        // Enable low for 5 cycles, code held at 08
        for (int i = 0; i < 5; i++)
            add(0, 8'h08, 0, mk(3, 1, 0, 1, 0, 0, 0, 0, S_TRACK));
        // Multi-bit code, then recovery on 0x20
        add(1, 8'h18, 0, mk(3, 0, 0, 1, 1, 0, 1, 1, S_FAULT));
        add(1, 8'h20, 0, mk(5, 1, 0, 1, 0, 0, 1, 1, S_TRACK));
        add(1, 8'h40, 0, mk(6, 1, 0, 1, 0, 0, 1, 1, S_TRACK));
        add(1, 8'h80, 0, mk(7, 1, 0, 1, 0, 0, 1, 1, S_TRACK));
        add(1, 8'h01, 0, mk(0, 1, 1, 2, 0, 0, 1, 1, S_TRACK));
        add(1, 8'h02, 0, mk(1, 1, 0, 2, 0, 0, 1, 1, S_TRACK));
        // Skipped step 02 -> 08, then 10 accepted
        add(1, 8'h08, 0, mk(3, 1, 0, 2, 0, 1, 1, 2, S_TRACK));
        add(1, 8'h10, 0, mk(4, 1, 0, 2, 0, 0, 1, 2, S_TRACK));
        // Clear together with an illegal code, then clear alone
        add(1, 8'h00, 1, mk(4, 0, 0, 2, 1, 0, 1, 1, S_FAULT));
        add(1, 8'h20, 1, mk(5, 1, 0, 2, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h40, 0, mk(6, 1, 0, 2, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h80, 0, mk(7, 1, 0, 2, 0, 0, 0, 0, S_TRACK));
        add(1, 8'h01, 0, mk(0, 1, 1, 3, 0, 0, 0, 0, S_TRACK));

        reset     = 1'b1;
        enable    = 1'b0;
        onehot_in = 8'h00;
        clear_err = 1'b0;
        #30;
        check("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
        #10;
        reset = 1'b0;  // released at 40 ns

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].code, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Advance to index 5, then reset mid-revolution
        step(1, 8'h02, 0);
        step(1, 8'h04, 0);
        step(1, 8'h08, 0);
        step(1, 8'h10, 0);
        step(1, 8'h20, 0);
        check("pre_reset_idx5", mk(5, 1, 0, 3, 0, 0, 0, 0, S_TRACK));
        reset = 1'b1;
        #1;
        check("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(1, 8'h01, 0);
        check("first_after_reset", mk(0, 1, 0, 0, 0, 0, 0, 0, S_TRACK));

        // 256 revolutions: rev_count wraps back to 0
        for (int r = 0; r < 256; r++) begin
            for (int b = 1; b <= 8; b++) begin
                logic [7:0] one;
                one = 8'h01;
                step(1, one << (b % 8), 0);
            end
            check($sformatf("rev%0d", r), mk(0, 1, 1, (r + 1) % 256, 0, 0, 0, 0, S_TRACK));
        end

        // 300 errors, alternating illegal code and legal recovery
        for (int k = 0; k < 300; k++) begin
            step(1, 8'h00, 0);
            check($sformatf("err%0d", k),
                  mk(0, 0, 0, 0, 1, 0, 1, (k + 1 > 255) ? 255 : k + 1, S_FAULT));
            if (k < 299) begin
                step(1, 8'h01, 0);
                check($sformatf("recover%0d", k),
                      mk(0, 1, 0, 0, 0, 0, 1, (k + 1 > 255) ? 255 : k + 1, S_TRACK));
            end
        end
        step(1, 8'h01, 1);
        check("clear_after_sat", mk(0, 1, 0, 0, 0, 0, 0, 0, S_TRACK));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/one_hot_monitor.md
Name: one_hot_monitor

Overview:
- Downstream consumer of the 8-bit one-hot ring counter. Samples the counter output and the same enable that drives the counter.
- Encodes the active bit to a binary index, counts full revolutions, and flags illegal codes and out-of-sequence steps.
- Sits between the counter and the status/debug logic as an on-line integrity checker.

Parameters:
- WIDTH, 8, number of one-hot bits; index width IW = $clog2(WIDTH).
- ROT_LEFT, 1, expected advance direction: 1 = bit i to bit i+1 (MSB wraps to bit 0); 0 = rotate right.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  the same enable that drives the counter; 1 means the counter advances this edge.
- onehot_in  input  WIDTH  counter output.
- clear_err  input  1  synchronous clear of err_sticky and err_count.
- index  output  IW  binary position of the active bit.
- index_valid  output  1  index holds a legal code.
- wrap_pulse  output  1  one-cycle pulse on an MSB-to-bit-0 advance (LSB-to-MSB when ROT_LEFT=0).
- rev_count  output  8  completed revolutions, modulo 256.
- illegal  output  1  one-cycle pulse: sampled code has zero or multiple bits set.
- seq_err  output  1  one-cycle pulse: legal code but not the expected successor.
- err_sticky  output  1  latched OR of illegal and seq_err.
- err_count  output  8  count of error events, saturating at 255.
- state  output  2  FSM state, for debug.

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0 and state = IDLE.
  - Internal prev_q = 0 and en_q = 0.
- Sampling:
  - Each rising edge compares the live onehot_in against prev_q and en_q, which were captured at the previous edge.
  - All outputs are registered, so results are visible one clock after the edge at which the code was sampled.
  - prev_q <= onehot_in and en_q <= enable on every edge.
- Legality: legal iff popcount(onehot_in) == 1.
- Expected value: expected = en_q ? rot(prev_q) : prev_q. rot follows ROT_LEFT.
- FSM states: IDLE=0, TRACK=1, FAULT=2.
  - IDLE:
    - Legal code -> TRACK, with index/index_valid updated; no sequence check this edge.
    - Illegal code -> illegal pulse, go to FAULT.
  - TRACK:
    - Illegal code -> illegal pulse, index_valid=0, go to FAULT.
    - Legal code != expected -> seq_err pulse, index updated, stay in TRACK (resynchronise on the new value).
    - Legal code == expected -> index updated.
  - FAULT:
    - Legal code -> TRACK, with no sequence check this edge.
    - Otherwise stay in FAULT with index_valid=0.
- Index: index = position of the set bit, valid only when legal. On an illegal code, index holds its previous value and index_valid = 0.
- Wrap detection:
  - wrap_pulse = 1 only in TRACK, when en_q=1, the code matches expected, and prev_q had the wrap-source bit set (bit WIDTH-1 when ROT_LEFT=1).
  - On wrap_pulse, rev_count increments, wrapping from 255 to 0.
- Errors:
  - Any illegal or seq_err pulse sets err_sticky and increments err_count, saturating at 255.
  - If clear_err and a new error occur on the same edge, the error wins: err_sticky=1 and err_count=1.
  - clear_err alone sets err_sticky=0 and err_count=0.
- Hold case: with enable held low, an unchanging legal code produces no errors.
- Reset mid-operation: the monitor returns to IDLE. The first code after release is never sequence-checked.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, TRACK, FAULT);
  - the rot() function;
  - the popcount-equals-one function;
  - the encoder function.
- One natural sub-module: onehot_encoder (combinational; onehot_in -> index, legal).

Test Plan:
- Reset released at 40 ns, enable=1, onehot_in advances 01,02,04,...,80,01 each clock:
  - TRACK reached;
  - index follows 0..7;
  - wrap_pulse fires once on the 80->01 step;
  - rev_count=1;
  - no errors.
- Enable=0 for 5 cycles with onehot_in held at 08: index=3 stable, seq_err=0, rev_count unchanged.
- Inject onehot_in=0x18 for one cycle in TRACK:
  - illegal pulse, index_valid=0, state FAULT;
  - next code 0x20 -> TRACK;
  - err_count=1, err_sticky=1.
- In TRACK at 0x02 with enable=1, inject 0x08 (skipped step):
  - seq_err pulse, index=3;
  - err_count increments;
  - the following 0x10 is accepted without error.
- Assert clear_err on the same edge as an illegal code -> err_sticky=1, err_count=1. clear_err alone next cycle -> both 0.
- Assert reset mid-revolution at index 5:
  - all outputs 0 immediately;
  - after release, the first 0x01 enters TRACK without seq_err.
- Run 256 revolutions -> rev_count wraps to 0. Force 300 errors -> err_count saturates at 255.
